// File: rtl/prbs_checker_rx_pkg.sv
// Shared types and helpers for the PRBS receive checker.
// State encoding, default PRBS polynomial/length and a popcount helper.
package prbs_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        CHECK = 2'd2
    } chk_state_t;

    localparam logic [31:0] PRBS_EQN_DEF = 32'h0010_0002;
    localparam int          PRBS_LEN_DEF = 32;

    // Counts set bits of a zero-extended vector; callers pass up to 64 lanes.
    function automatic logic [7:0] popcount(input logic [63:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prbs_checker_rx_lane.sv
// One PRBS lane predictor: received-bit history, tap-parity prediction
// and per-bit error flag. Self-synchronizing: the received bit is shifted in.
module prbs_checker_lane
    import prbs_rx_pkg::*;
#(
    parameter int N_PRBS = PRBS_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic [N_PRBS-1:0] eqn,
    input  logic              b,
    output logic              e
);

    logic [N_PRBS-1:0] hist;
    logic              pred;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= {hist[N_PRBS-2:0], b};
        end
    end

    assign pred = ^(hist & eqn);
    assign e    = b ^ pred;

endmodule

// File: rtl/prbs_checker_rx.sv
// Multi-lane PRBS receive checker: self-seeding per-lane predictors, lock FSM,
// saturating counters. Optional per-lane error counters under PRBS_CHK_LANE_CNT_EN.
module prbs_checker_rx
    import prbs_rx_pkg::*;
#(
    parameter int N_LANES    = 16,
    parameter int N_PRBS     = PRBS_LEN_DEF,
    parameter int CNT_W      = 32,
    parameter int WIN_LEN    = 256,
    parameter int LOL_THRESH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr_cnt,
    input  logic [N_PRBS-1:0]  eqn,
    input  logic               inv,
    input  logic [N_LANES-1:0] din,
    output logic               lock,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   bit_cnt,
    output logic [N_LANES-1:0] err_lane,
    output logic [7:0]         lol_cnt
`ifdef PRBS_CHK_LANE_CNT_EN
    ,
    output logic [15:0]        lane_err_cnt [N_LANES]
`endif
);

    localparam int SEED_W   = (N_PRBS > 1) ? $clog2(N_PRBS) : 1;
    localparam int WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WERR_MAX = 2 * LOL_THRESH;
    localparam int WERR_W   = $clog2(WERR_MAX + N_LANES + 1);

    chk_state_t         state;
    chk_state_t         state_nxt;
    logic               lol_evt;
    logic [SEED_W-1:0]  seed_cnt;
    logic [WIN_W-1:0]   win_cyc;
    logic [WERR_W-1:0]  win_err;
    logic [WERR_W-1:0]  win_err_sum;
    logic [WERR_W-1:0]  win_err_sat;
    logic [N_LANES-1:0] b;
    logic [N_LANES-1:0] e;
    logic [7:0]         err_inc;
    logic [CNT_W:0]     err_sum;
    logic [CNT_W:0]     bit_sum;
    logic               shift_en;
    logic               count_en;

    assign b        = din ^ {N_LANES{inv}};
    assign shift_en = (state != IDLE);
    assign count_en = (state == CHECK) && en;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        prbs_checker_lane #(
            .N_PRBS(N_PRBS)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .shift_en(shift_en),
            .eqn     (eqn),
            .b       (b[i]),
            .e       (e[i])
        );
    end

    assign err_inc     = popcount(64'(e));
    assign err_sum     = {1'b0, err_cnt} + (CNT_W+1)'(err_inc);
    assign bit_sum     = {1'b0, bit_cnt} + (CNT_W+1)'(N_LANES);
    assign win_err_sum = win_err + WERR_W'(err_inc);
    assign win_err_sat = (win_err_sum > WERR_W'(WERR_MAX)) ? WERR_W'(WERR_MAX) : win_err_sum;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        lol_evt   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = SEED;
                SEED:  if (seed_cnt == SEED_W'(N_PRBS-1)) state_nxt = CHECK;
                CHECK: begin
                    if (win_err > WERR_W'(LOL_THRESH)) begin
                        state_nxt = SEED;
                        lol_evt   = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock     <= 1'b0;
            seed_cnt <= '0;
            win_cyc  <= '0;
            win_err  <= '0;
        end else begin
            state <= state_nxt;
            lock  <= (state_nxt == CHECK);

            if (state_nxt == SEED && state != SEED) begin
                seed_cnt <= '0;
            end else if (state == SEED) begin
                seed_cnt <= seed_cnt + SEED_W'(1);
            end

            // Window restarts on every CHECK entry; win_cyc wraps naturally (power of 2).
            if (state_nxt == CHECK && state != CHECK) begin
                win_cyc <= '0;
                win_err <= '0;
            end else if (count_en) begin
                win_cyc <= win_cyc + WIN_W'(1);
                win_err <= (win_cyc == WIN_W'(WIN_LEN-1)) ? WERR_W'(err_inc) : win_err_sat;
            end
        end
    end

    // clr_cnt wins over any same-cycle increment, including a loss-of-lock event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt  <= '0;
            bit_cnt  <= '0;
            err_lane <= '0;
            lol_cnt  <= '0;
        end else if (clr_cnt) begin
            err_cnt  <= '0;
            bit_cnt  <= '0;
            err_lane <= '0;
            lol_cnt  <= '0;
        end else begin
            if (count_en) begin
                err_cnt  <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                bit_cnt  <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
                err_lane <= err_lane | e;
            end
            if (lol_evt && lol_cnt != 8'hFF) begin
                lol_cnt <= lol_cnt + 8'd1;
            end
        end
    end

`ifdef PRBS_CHK_LANE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) lane_err_cnt[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < N_LANES; i++) lane_err_cnt[i] <= '0;
        end else if (count_en) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (e[i] && lane_err_cnt[i] != 16'hFFFF) begin
                    lane_err_cnt[i] <= lane_err_cnt[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_prbs_checker_rx.sv
// Directed bench for prbs_checker_rx: lock timing, error injection, loss of lock,
// inversion, counter clear, saturation (narrow instance) and async reset.
module tb_prbs_checker_rx;

    localparam logic [31:0] EQN = 32'h0010_0002;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr_cnt;
    logic        inv;
    logic [15:0] din;
    logic        lock;
    logic [31:0] err_cnt;
    logic [31:0] bit_cnt;
    logic [15:0] err_lane;
    logic [7:0]  lol_cnt;

    // Narrow instance: predictor forced to 0 against all-ones data, so every bit errs.
    logic        lock2;
    logic [7:0]  err_cnt2;
    logic [7:0]  bit_cnt2;
    logic [15:0] err_lane2;
    logic [7:0]  lol_cnt2;

    logic [31:0] lfsr [16];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    prbs_checker_rx dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr_cnt (clr_cnt),
        .eqn     (EQN),
        .inv     (inv),
        .din     (din),
        .lock    (lock),
        .err_cnt (err_cnt),
        .bit_cnt (bit_cnt),
        .err_lane(err_lane),
        .lol_cnt (lol_cnt)
    );

    prbs_checker_rx #(
        .CNT_W     (8),
        .WIN_LEN   (4),
        .LOL_THRESH(200)
    ) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr_cnt (1'b0),
        .eqn     (32'h0),
        .inv     (1'b0),
        .din     (16'hFFFF),
        .lock    (lock2),
        .err_cnt (err_cnt2),
        .bit_cnt (bit_cnt2),
        .err_lane(err_lane2),
        .lol_cnt (lol_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference TX LFSRs one word, drive it XOR mask, then wait one edge.
    task automatic step(input logic [15:0] mask);
        logic [15:0] word;
        for (int i = 0; i < 16; i++) begin
            word[i] = ^(lfsr[i] & EQN);
            lfsr[i] = {lfsr[i][30:0], word[i]};
        end
        din = word ^ mask;
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand();
        din = 16'($urandom);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) lfsr[i] = {16'(i + 1), 16'hB5A3};
        rst     = 1'b1;
        en      = 1'b0;
        clr_cnt = 1'b0;
        inv     = 1'b0;
        din     = '0;
        #2;
        check("rst_lock",     64'(lock),     64'd0);
        check("rst_err_cnt",  64'(err_cnt),  64'd0);
        check("rst_bit_cnt",  64'(bit_cnt),  64'd0);
        check("rst_err_lane", 64'(err_lane), 64'd0);
        check("rst_lol_cnt",  64'(lol_cnt),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: lock appears 33 edges after en, then 16 bits per CHECK edge
        en = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            step(16'h0);
            if (c == 32) check("lock_before_33", 64'(lock), 64'd0);
        end
        check("lock_at_33",      64'(lock),    64'd1);
        check("lock2_at_33",     64'(lock2),   64'd1);
        check("bit_cnt_at_lock", 64'(bit_cnt), 64'd0);
        repeat (10) step(16'h0);
        check("err_cnt_clean",  64'(err_cnt),  64'd0);
        check("bit_cnt_10",     64'(bit_cnt),  64'd160);
        check("err_cnt2_10",    64'(err_cnt2), 64'd160);
        repeat (5) step(16'h0);
        check("err_cnt2_15",    64'(err_cnt2), 64'd240);
        step(16'h0);
        check("err_cnt2_sat",   64'(err_cnt2), 64'd255);
        check("bit_cnt2_sat",   64'(bit_cnt2), 64'd255);
        repeat (4) step(16'h0);
        check("err_cnt2_hold",  64'(err_cnt2),  64'd255);
        check("err_lane2",      64'(err_lane2), 64'hFFFF);
        check("lock2_kept",     64'(lock2),     64'd1);
        check("lol_cnt2",       64'(lol_cnt2),  64'd0);
        check("bit_cnt_20",     64'(bit_cnt),   64'd320);
        check("lock_kept",      64'(lock),      64'd1);

        // 2: one flipped bit on lane 5 yields three error flags
        step(16'h0020);
        check("single_err_now",  64'(err_cnt),  64'd1);
        check("single_lane_now", 64'(err_lane), 64'h0020);
        repeat (25) step(16'h0);
        check("single_err_total", 64'(err_cnt),  64'd3);
        check("single_err_lane",  64'(err_lane), 64'h0020);
        check("single_lock",      64'(lock),     64'd1);

        // 3: random data drops lock within a window; PRBS relocks 32 edges later
        for (int c = 0; c < 256 && lock; c++) step_rand();
        check("lol_random_lock", 64'(lock),    64'd0);
        check("lol_random_cnt",  64'(lol_cnt), 64'd1);
        for (int c = 1; c <= 32; c++) begin
            step(16'h0);
            if (c == 31) check("relock_before_32", 64'(lock), 64'd0);
        end
        check("relock_at_32", 64'(lock), 64'd1);

        // 5: clear coincident with an injected error on lane 8
        clr_cnt = 1'b1;
        step(16'h0100);
        clr_cnt = 1'b0;
        check("clr_err_cnt",  64'(err_cnt),  64'd0);
        check("clr_bit_cnt",  64'(bit_cnt),  64'd0);
        check("clr_err_lane", 64'(err_lane), 64'd0);
        check("clr_lol_cnt",  64'(lol_cnt),  64'd0);
        check("clr_lock",     64'(lock),     64'd1);
        repeat (24) step(16'h0);
        check("post_clr_err_cnt",  64'(err_cnt),  64'd2);
        check("post_clr_err_lane", 64'(err_lane), 64'h0100);
        check("post_clr_bit_cnt",  64'(bit_cnt),  64'd384);

        // 4: inverted PRBS with inv=1 locks cleanly; inv=0 loses lock
        en = 1'b0;
        step(16'h0);
        check("en_off_lock",    64'(lock),    64'd0);
        check("en_off_err_cnt", 64'(err_cnt), 64'd2);
        check("en_off_bit_cnt", 64'(bit_cnt), 64'd384);
        clr_cnt = 1'b1;
        step(16'h0);
        clr_cnt = 1'b0;
        inv = 1'b1;
        en  = 1'b1;
        repeat (33) step(16'hFFFF);
        check("inv_lock", 64'(lock), 64'd1);
        repeat (10) step(16'hFFFF);
        check("inv_err_cnt", 64'(err_cnt), 64'd0);
        check("inv_bit_cnt", 64'(bit_cnt), 64'd160);
        inv = 1'b0;
        for (int c = 0; c < 256 && lock; c++) step(16'hFFFF);
        check("noinv_lol_lock", 64'(lock),    64'd0);
        check("noinv_lol_cnt",  64'(lol_cnt), 64'd1);

        // 6: async reset mid-CHECK, then en drop holds counters
        for (int c = 0; c < 100 && !lock; c++) step(16'h0);
        check("relock_normal", 64'(lock), 64'd1);
        repeat (5) step(16'h0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_lock",     64'(lock),     64'd0);
        check("async_rst_err_cnt",  64'(err_cnt),  64'd0);
        check("async_rst_bit_cnt",  64'(bit_cnt),  64'd0);
        check("async_rst_err_lane", 64'(err_lane), 64'd0);
        check("async_rst_lol_cnt",  64'(lol_cnt),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            step(16'h0);
            if (c == 32) check("rst_relock_before_33", 64'(lock), 64'd0);
        end
        check("rst_relock_at_33", 64'(lock), 64'd1);
        repeat (4) step(16'h0);
        check("pre_drop_bit_cnt", 64'(bit_cnt), 64'd64);
        en = 1'b0;
        step(16'h0);
        check("drop_lock",    64'(lock),    64'd0);
        check("drop_bit_cnt", 64'(bit_cnt), 64'd64);
        step(16'h0);
        check("idle_bit_cnt", 64'(bit_cnt), 64'd64);
        check("idle_err_cnt", 64'(err_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
